ps2_keyboard_receiver: RTL and testbench
========================================

# ps2_keyboard_receiver

PS/2 keyboard front end for the memory-mapped keyboard peripheral. It samples the raw PS2_KBCLK/PS2_KBDAT lines in the CLOCK_50 domain and deframes 11-bit device-to-host frames. It decodes make/break/extended prefixes and maintains two 64-bit registers, REG0 and REG1. The address-decoding converter stage directly downstream selects between these two registers and drives them onto the bus.

## Interface
- FILTER_LEN, 8: consecutive equal synchronized samples required to change the filtered PS/2 clock level.
- TIMEOUT_CYCLES, 50000: CLOCK_50 cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
- CLOCK_50  input  1  system clock; all state is on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- PS2_KBCLK  input  1  raw keyboard clock, idle high.
- PS2_KBDAT  input  1  raw keyboard data, idle high.
- REG0  output  64  history of the last 8 accepted bytes; newest byte in [7:0].
- REG1  output  64  decoded key status and counters (layout below).
- BYTE  output  8  last accepted byte.
- BYTE_VALID  output  1  one-cycle pulse per accepted byte.

## Operation
- **Input synchronizer:** two-flop synchronizer on each input.
- **Clock filter:**
  - A FILTER_LEN-bit shift register holds the synchronized clock.
  - Filtered clock goes to 1 when all bits are 1, goes to 0 when all bits are 0, and holds otherwise.
  - A sample event is a 1→0 transition of the filtered clock. Synchronized data is sampled in that cycle.
- **Frame FSM (states IDLE, DATA, PARITY, STOP; transitions occur only on sample events except timeout):**
  - IDLE: data=0 → DATA, bit counter=0. Data=1 → stay in IDLE (spurious edge, no count).
  - DATA: shift the sample in LSB first. After the 8th bit → PARITY.
  - PARITY: store the sample → STOP.
  - STOP: the frame is good if the sample is 1 and XOR(8 data bits, parity bit)=1 (odd parity). Good frame → accept byte. Otherwise increment the error count. → IDLE.
  - Timeout: a counter clears on every sample event and counts while not in IDLE. Reaching TIMEOUT_CYCLES-1 → discard the frame, increment the timeout count, go to IDLE. A sample event in the same cycle as the terminal count wins; no timeout occurs.
- **Accepting a byte:** BYTE ← byte; REG0 ← {REG0[55:0], byte}; byte count +1.
- **Decode (accepted bytes only):**
  - 0xE0 sets ext_pending.
  - 0xF0 sets brk_pending.
  - A repeated prefix leaves its pending flag set.
  - Any other byte (including 0xE1) is a key event:
    - last_code ← byte; last_ext ← ext_pending; last_break ← brk_pending.
    - Both pending flags clear; event count +1.
- **REG1 layout:**
  - [7:0] last_code
  - [8] last_ext
  - [9] last_break (1 = release)
  - [10] key_held = !last_break (0 until the first event)
  - [15:11] always 0
  - [31:16] event count, 16-bit, wraps FFFF→0000
  - [47:32] byte count, 16-bit, wraps FFFF→0000
  - [55:48] parity/stop error count, saturates at 0xFF
  - [63:56] timeout count, saturates at 0xFF

## Timing
- **Reset (asynchronous):**
  - REG0, REG1, BYTE = 0; BYTE_VALID = 0.
  - FSM = IDLE; pending flags, counters and timer = 0.
  - Synchronizer and filter flops load 1 (idle-high line); filtered clock = 1.
- Reset asserted mid-frame aborts the frame. No counts are kept.
- BYTE, REG0, REG1 and BYTE_VALID=1 all update on the same edge: the edge registering the stop-bit sample event. Values hold until the next accepted byte. BYTE_VALID drops on the following edge.
- Latency from the stop-bit fall on PS2_KBCLK (line stable) to BYTE_VALID: exactly FILTER_LEN+3 CLOCK_50 cycles (2 synchronizer + FILTER_LEN filter + 1 register).
- Bad or timed-out frames produce no BYTE_VALID and leave REG0, BYTE, the REG1 key fields and the pending flags unchanged. Only the relevant error count changes, on the stop-sample or timeout edge.
- Clock glitches shorter than FILTER_LEN cycles produce no sample event.

## Test plan
- **Reset:** assert RESET, release → REG0=0, REG1=0, BYTE=0, BYTE_VALID=0; idle lines for 1000 cycles → no change.
- **Single make code:** valid frame 0x1C (parity bit 0) → one BYTE_VALID pulse FILTER_LEN+3 cycles after the stop fall; BYTE=0x1C, REG0=0x1C; REG1=0x0000_0001_0001_041C.
- **Extended break:** frames E0, F0, 75 after the previous scenario → exactly 3 BYTE_VALID pulses; REG0[31:0]=0x1CE0F075; REG1[10:0]=0x375; event count=2, byte count=4.
- **Frame errors:** 0x1C with parity bit 1, then 0x1C with stop bit 0 → no BYTE_VALID; REG1[55:48]=2; REG0 unchanged.
- **Timeout then recovery:** start bit + 4 data bits, then clock idle TIMEOUT_CYCLES+10 cycles → REG1[63:56]=1; a following valid 0x29 frame is accepted with BYTE=0x29.
- **Glitch and mid-frame reset:** 3-cycle low pulse on PS2_KBCLK → no state change. RESET pulsed after the 5th data bit → all outputs 0; the next valid 0x5A frame gives REG0=0x5A and event count 1.

Source files
------------

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, deframes
// 11-bit frames, decodes E0/F0 prefixes and keeps history/status registers.
module ps2_keyboard_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        PS2_KBCLK,
  input  logic        PS2_KBDAT,
  output logic [63:0] REG0,
  output logic [63:0] REG1,
  output logic [7:0]  BYTE,
  output logic        BYTE_VALID
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] filt_sh;
  logic                  filt_clk;
  logic                  sample;
  logic                  data_bit;

  state_t       state;
  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic         par;
  logic [TW-1:0] timer;

  logic         ext_pending;
  logic         brk_pending;
  logic [7:0]   last_code;
  logic         last_ext;
  logic         last_break;
  logic         have_event;
  logic [15:0]  evt_cnt;
  logic [15:0]  byte_cnt;
  logic [7:0]   err_cnt;
  logic [7:0]   to_cnt;

  // Sample event fires in the cycle the filtered clock is about to fall.
  assign sample   = filt_clk && (filt_sh == '0);
  assign data_bit = dat_sync[1];

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_sh  <= '1;
      filt_clk <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_KBCLK};
      dat_sync <= {dat_sync[0], PS2_KBDAT};
      filt_sh  <= {filt_sh[FILTER_LEN-2:0], clk_sync[1]};
      if (filt_sh == '1)
        filt_clk <= 1'b1;
      else if (filt_sh == '0)
        filt_clk <= 1'b0;
    end
  end

  // BYTE_VALID is a one-cycle strobe with no back-pressure: BYTE/REG0/REG1
  // change on the same edge it rises and hold until the next accepted byte.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      timer       <= '0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      last_code   <= '0;
      last_ext    <= 1'b0;
      last_break  <= 1'b0;
      have_event  <= 1'b0;
      evt_cnt     <= '0;
      byte_cnt    <= '0;
      err_cnt     <= '0;
      to_cnt      <= '0;
      REG0        <= '0;
      BYTE        <= '0;
      BYTE_VALID  <= 1'b0;
    end else begin
      BYTE_VALID <= 1'b0;
      if (sample) begin
        timer <= '0;
        case (state)
          IDLE: begin
            if (!data_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= data_bit;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_bit && (^{shreg, par})) begin
              BYTE       <= shreg;
              BYTE_VALID <= 1'b1;
              REG0       <= {REG0[55:0], shreg};
              byte_cnt   <= byte_cnt + 16'd1;
              if (shreg == 8'hE0) begin
                ext_pending <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk_pending <= 1'b1;
              end else begin
                last_code   <= shreg;
                last_ext    <= ext_pending;
                last_break  <= brk_pending;
                have_event  <= 1'b1;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
                evt_cnt     <= evt_cnt + 16'd1;
              end
            end else if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          timer <= '0;
          if (to_cnt != 8'hFF)
            to_cnt <= to_cnt + 8'd1;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  assign REG1 = {to_cnt, err_cnt, byte_cnt, evt_cnt, 5'b0,
                 have_event & ~last_break, last_break, last_ext, last_code};

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver: frames, prefixes, errors,
// timeout, glitch rejection and mid-frame reset.
module tb_ps2_keyboard_receiver;

  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        kbclk = 1'b1;
  logic        kbdat = 1'b1;
  logic [63:0] reg0;
  logic [63:0] reg1;
  logic [7:0]  byte_out;
  logic        byte_valid;

  int cyc = 0;
  int stop_cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  ps2_keyboard_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .PS2_KBCLK (kbclk),
    .PS2_KBDAT (kbdat),
    .REG0      (reg0),
    .REG1      (reg1),
    .BYTE      (byte_out),
    .BYTE_VALID(byte_valid)
  );

  // clock / cycle counter / pulse monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (byte_valid) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of a frame; parity and stop bit can be corrupted.
  task automatic send_frame(input logic [7:0] b, input bit par_flip,
                            input bit stop_val, input int nbits);
    logic [10:0] bits;
    bits = {stop_val, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      kbdat = bits[i];
      wait_cycles(HALF);
      kbclk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cycles(HALF);
      kbclk = 1'b1;
    end
    kbdat = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reset();
    int p0;
    pulse_reset();
    n_cmp++; if (reg0 !== 64'h0) begin n_bad++; $display("FAIL reset_reg0: got %h want %h", reg0, 64'h0); end
    n_cmp++; if (reg1 !== 64'h0) begin n_bad++; $display("FAIL reset_reg1: got %h want %h", reg1, 64'h0); end
    n_cmp++; if (byte_out !== 8'h0) begin n_bad++; $display("FAIL reset_byte: got %h want %h", byte_out, 8'h0); end
    n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
    p0 = pulse_cnt;
    wait_cycles(1000);
    n_cmp++; if (reg0 !== 64'h0 || reg1 !== 64'h0) begin n_bad++; $display("FAIL idle_regs: got %h/%h want 0/0", reg0, reg1); end
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_bad++; $display("FAIL idle_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_single_make();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    wait_cycles(5);
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL make_pulses: got %0d want 1", pulse_cnt - p0); end
    n_cmp++; if (pulse_cyc - stop_cyc !== FL + 3) begin n_bad++; $display("FAIL make_latency: got %0d want %0d", pulse_cyc - stop_cyc, FL + 3); end
    n_cmp++; if (byte_out !== 8'h1C) begin n_bad++; $display("FAIL make_byte: got %h want 1c", byte_out); end
    n_cmp++; if (reg0 !== 64'h1C) begin n_bad++; $display("FAIL make_reg0: got %h want %h", reg0, 64'h1C); end
    n_cmp++; if (reg1 !== 64'h0000_0001_0001_041C) begin n_bad++; $display("FAIL make_reg1: got %h want %h", reg1, 64'h0000_0001_0001_041C); end
  endtask

  task automatic test_ext_break();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'hE0, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    n_cmp++; if (reg1[10:0] !== 11'h41C) begin n_bad++; $display("FAIL prefix_holds_key: got %h want 41c", reg1[10:0]); end
    send_frame(8'h75, 1'b0, 1'b1, 11);
    wait_cycles(5);
    n_cmp++; if (pulse_cnt - p0 !== 3) begin n_bad++; $display("FAIL ext_pulses: got %0d want 3", pulse_cnt - p0); end
    n_cmp++; if (reg0 !== 64'h0000_0000_1CE0_F075) begin n_bad++; $display("FAIL ext_reg0: got %h want %h", reg0, 64'h1CE0_F075); end
    n_cmp++; if (reg1 !== 64'h0000_0004_0002_0375) begin n_bad++; $display("FAIL ext_reg1: got %h want %h", reg1, 64'h0000_0004_0002_0375); end
    n_cmp++; if (byte_out !== 8'h75) begin n_bad++; $display("FAIL ext_byte: got %h want 75", byte_out); end
  endtask

  task automatic test_frame_errors();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    wait_cycles(5);
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_bad++; $display("FAIL err_pulses: got %0d want 0", pulse_cnt - p0); end
    n_cmp++; if (reg1 !== 64'h0002_0004_0002_0375) begin n_bad++; $display("FAIL err_reg1: got %h want %h", reg1, 64'h0002_0004_0002_0375); end
    n_cmp++; if (reg0 !== 64'h0000_0000_1CE0_F075) begin n_bad++; $display("FAIL err_reg0: got %h want %h", reg0, 64'h1CE0_F075); end
    n_cmp++; if (byte_out !== 8'h75) begin n_bad++; $display("FAIL err_byte: got %h want 75", byte_out); end
  endtask

  task automatic test_timeout();
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h33, 1'b0, 1'b1, 5);
    wait_cycles(TO + 10);
    n_cmp++; if (reg1 !== 64'h0102_0004_0002_0375) begin n_bad++; $display("FAIL timeout_reg1: got %h want %h", reg1, 64'h0102_0004_0002_0375); end
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_bad++; $display("FAIL timeout_pulses: got %0d want 0", pulse_cnt - p0); end
    send_frame(8'h29, 1'b0, 1'b1, 11);
    wait_cycles(5);
    n_cmp++; if (byte_out !== 8'h29) begin n_bad++; $display("FAIL recover_byte: got %h want 29", byte_out); end
    n_cmp++; if (reg0 !== 64'h0000_001C_E0F0_7529) begin n_bad++; $display("FAIL recover_reg0: got %h want %h", reg0, 64'h1C_E0F0_7529); end
    n_cmp++; if (reg1 !== 64'h0102_0005_0003_0429) begin n_bad++; $display("FAIL recover_reg1: got %h want %h", reg1, 64'h0102_0005_0003_0429); end
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulse_cnt;
    @(negedge clk);
    kbdat = 1'b0;
    kbclk = 1'b0;
    wait_cycles(3);
    kbclk = 1'b1;
    wait_cycles(2);
    kbdat = 1'b1;
    wait_cycles(50);
    n_cmp++; if (reg1 !== 64'h0102_0005_0003_0429) begin n_bad++; $display("FAIL glitch_reg1: got %h want %h", reg1, 64'h0102_0005_0003_0429); end
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d want 0", pulse_cnt - p0); end
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    wait_cycles(5);
    n_cmp++; if (byte_out !== 8'h1C || pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL glitch_align: got %h/%0d want 1c/1", byte_out, pulse_cnt - p0); end
  endtask

  task automatic test_mid_reset();
    send_frame(8'hA5, 1'b0, 1'b1, 6);
    pulse_reset();
    n_cmp++; if (reg0 !== 64'h0 || reg1 !== 64'h0) begin n_bad++; $display("FAIL midrst_regs: got %h/%h want 0/0", reg0, reg1); end
    n_cmp++; if (byte_out !== 8'h0 || byte_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_byte: got %h/%b want 00/0", byte_out, byte_valid); end
    wait_cycles(20);
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    wait_cycles(5);
    n_cmp++; if (reg0 !== 64'h5A) begin n_bad++; $display("FAIL post_reg0: got %h want %h", reg0, 64'h5A); end
    n_cmp++; if (reg1 !== 64'h0000_0001_0001_045A) begin n_bad++; $display("FAIL post_reg1: got %h want %h", reg1, 64'h0000_0001_0001_045A); end
    n_cmp++; if (byte_out !== 8'h5A) begin n_bad++; $display("FAIL post_byte: got %h want 5a", byte_out); end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_ext_break();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
